// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: receiver state encoding, parity selectors, baud helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Used by recv_rs232 and intended to be shared with the transmitter so both
// ends derive bit timing from the same arithmetic.
package rs232_pkg;

  // Receiver deframer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  // Parity selectors. The value doubles as the initial parity accumulator
  // (odd starts at 0, even starts at 1).
  localparam int PAR_ODD  = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_NONE = -1;

  // Core clocks per line bit (integer division, truncating).
  function automatic int calc_bitperiod(input int fclk, input int bps);
    return fclk / bps;
  endfunction

  // Offset into the start bit where it is re-checked (mid-bit).
  function automatic int calc_half(input int bitperiod);
    return bitperiod / 2;
  endfunction

endpackage

// File: rtl/recv_rs232_if.sv
// Byte delivery bus from the RS-232 receiver to its consumer.
// Latency: n/a (wires only).
// Backpressure: valid/ready; the receiver holds data and flags until data_ready.
//
// Signals:
//   data        received byte, stable while data_valid
//   data_valid  byte available, held until accepted
//   data_ready  consumer accepts when data_valid && data_ready
//   parity_err  parity mismatch for the held byte (qualified by data_valid)
//   frame_err   stop bit was low for the held byte (qualified by data_valid)
//   overrun     one-cycle pulse: a completed byte was dropped, buffer full
interface recv_rs232_if;

  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  // Receiver side.
  modport master (
    output data,
    output data_valid,
    output parity_err,
    output frame_err,
    output overrun,
    input  data_ready
  );

  // Consumer side.
  modport slave (
    input  data,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    input  overrun,
    output data_ready
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none.
//
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized).
// rst_val sets the value both flops take in reset, so a line that idles high
// can be synchronized without a spurious edge when reset releases.
module sync2 #(
  parameter logic rst_val = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= rst_val;
      q    <= rst_val;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/recv_rs232.sv
// RS-232 receiver: deframes 8N1/8O1/8E1 characters (LSB first) from rx into a one-entry buffer.
// Latency: data_valid rises 1 clk after the stop-bit sample (E+half+9/10*bitperiod+1).
// Backpressure: one held byte; a byte completing while the buffer is full and not being accepted is dropped and overrun pulses.
//
// Ports:
//   clk    sole clock
//   rst_n  asynchronous assert, active-low reset
//   rx     serial line, idle high, asynchronous to clk
//   bus    recv_rs232_if.master: data/data_valid/data_ready, parity_err,
//          frame_err, overrun
module recv_rs232
  import rs232_pkg::*;
#(
  parameter int bps    = 115200,
  parameter int parity = PAR_ODD,
  parameter int fclk   = 26000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx,
  recv_rs232_if.master bus
);

  localparam int bitperiod = calc_bitperiod(fclk, bps);
  localparam int half      = calc_half(bitperiod);
  localparam int BCW       = $clog2(bitperiod) + 1;

  localparam logic [BCW-1:0] BC_LAST  = BCW'(bitperiod - 1);
  localparam logic [BCW-1:0] BC_HALF  = BCW'(half - 1);
  localparam logic           PAR_EN   = (parity != PAR_NONE);
  localparam logic           PAR_INIT = (parity == PAR_EVEN);

  // Synchronized line and its one-cycle-old copy for edge detection.
  logic rxs;
  logic rxs_d;

  rx_state_t state;
  rx_state_t state_nxt;

  logic [BCW-1:0] baudclk;
  logic [BCW-1:0] baudclk_nxt;
  logic [2:0]     bitcnt;
  logic [7:0]     shreg;
  logic           par_acc;
  logic           par_bad;

  // Decoded sampling strobes.
  logic start_edge;
  logic start_smp;
  logic bit_tick;
  logic data_smp;
  logic last_bit;
  logic par_smp;
  logic stop_smp;

  // One-entry output buffer.
  logic [7:0] data_q;
  logic       data_valid_q;
  logic       perr_q;
  logic       ferr_q;
  logic       overrun_q;

  // Both flops reset high so releasing reset never looks like a start edge.
  sync2 #(.rst_val(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rxs)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: output / strobe decode
  // ---------------------------------------------------------------------
  always_comb begin
    start_edge  = 1'b0;
    start_smp   = 1'b0;
    bit_tick    = (baudclk == BC_LAST);
    data_smp    = 1'b0;
    last_bit    = (bitcnt == 3'd7);
    par_smp     = 1'b0;
    stop_smp    = 1'b0;
    baudclk_nxt = '0;

    case (state)
      ST_IDLE: begin
        start_edge = rxs_d & ~rxs;
      end
      ST_START: begin
        start_smp = (baudclk == BC_HALF);
        // Counter restarts at the mid-start check so later samples land
        // mid-bit, one bitperiod apart.
        baudclk_nxt = start_smp ? '0 : baudclk + BCW'(1);
      end
      ST_DATA: begin
        data_smp    = bit_tick;
        baudclk_nxt = bit_tick ? '0 : baudclk + BCW'(1);
      end
      ST_PARITY: begin
        par_smp     = bit_tick;
        baudclk_nxt = bit_tick ? '0 : baudclk + BCW'(1);
      end
      ST_STOP: begin
        stop_smp    = bit_tick;
        baudclk_nxt = bit_tick ? '0 : baudclk + BCW'(1);
      end
      default: begin
        // IDLE and BREAK hold the counter at zero.
        baudclk_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: next-state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_edge) state_nxt = ST_START;
      end
      ST_START: begin
        // Line back high at mid-start: a glitch, not a character.
        if (start_smp) state_nxt = rxs ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (data_smp && last_bit) state_nxt = PAR_EN ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (par_smp) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        // Leaving mid-stop-bit lets a back-to-back start edge be caught.
        if (stop_smp) state_nxt = rxs ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: begin
        if (rxs) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Deframing datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxs_d   <= 1'b1;
      baudclk <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      par_acc <= 1'b0;
      par_bad <= 1'b0;
    end else begin
      rxs_d   <= rxs;
      baudclk <= baudclk_nxt;

      if (start_edge) begin
        par_acc <= PAR_INIT;
        par_bad <= 1'b0;
      end

      if (start_smp && !rxs) begin
        bitcnt <= '0;
      end

      if (data_smp) begin
        // LSB arrives first: insert at the top and shift down.
        shreg   <= {rxs, shreg[7:1]};
        par_acc <= par_acc ^ rxs;
        bitcnt  <= bitcnt + 3'd1;
      end

      // The parity bit must equal the inverted accumulator; with odd parity
      // that makes the ones count over data plus parity bit odd.
      if (par_smp) begin
        par_bad <= (rxs != ~par_acc);
      end
    end
  end

  // ---------------------------------------------------------------------
  // One-entry output buffer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (stop_smp) begin
        // An accept in this same cycle frees the slot for the new byte.
        if (!data_valid_q || bus.data_ready) begin
          data_q       <= shreg;
          perr_q       <= par_bad;
          ferr_q       <= ~rxs;
          data_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (data_valid_q && bus.data_ready) begin
        data_valid_q <= 1'b0;
      end
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_recv_rs232.sv
// Bench for recv_rs232: three receivers (odd, even, no parity) at 16 clocks per bit.
// Latency: expected byte timing is derived from the frame start on the pin.
// Backpressure: data_ready driven per receiver, directed and randomized.
module tb_recv_rs232;

  localparam int BP   = 16;
  localparam int HALF = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx_l [3];
  logic rdy  [3];
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  recv_rs232_if bus0 ();
  recv_rs232_if bus1 ();
  recv_rs232_if bus2 ();

  recv_rs232 #(.bps(1), .parity(0),  .fclk(16)) dut0 (.clk(clk), .rst_n(rst_n), .rx(rx_l[0]), .bus(bus0));
  recv_rs232 #(.bps(1), .parity(1),  .fclk(16)) dut1 (.clk(clk), .rst_n(rst_n), .rx(rx_l[1]), .bus(bus1));
  recv_rs232 #(.bps(1), .parity(-1), .fclk(16)) dut2 (.clk(clk), .rst_n(rst_n), .rx(rx_l[2]), .bus(bus2));

  assign bus0.data_ready = rdy[0];
  assign bus1.data_ready = rdy[1];
  assign bus2.data_ready = rdy[2];

  logic       o_vld [3];
  logic [7:0] o_dat [3];
  logic       o_pe  [3];
  logic       o_fe  [3];
  logic       o_ov  [3];

  assign o_vld[0] = bus0.data_valid; assign o_dat[0] = bus0.data;
  assign o_pe[0]  = bus0.parity_err; assign o_fe[0]  = bus0.frame_err; assign o_ov[0] = bus0.overrun;
  assign o_vld[1] = bus1.data_valid; assign o_dat[1] = bus1.data;
  assign o_pe[1]  = bus1.parity_err; assign o_fe[1]  = bus1.frame_err; assign o_ov[1] = bus1.overrun;
  assign o_vld[2] = bus2.data_valid; assign o_dat[2] = bus2.data;
  assign o_pe[2]  = bus2.parity_err; assign o_fe[2]  = bus2.frame_err; assign o_ov[2] = bus2.overrun;

  // Expected completed characters: which receiver, the cycle its stop bit is
  // sampled, and what it must deliver.
  typedef struct {
    int         idx;
    int         cyc;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } ev_t;

  ev_t        evq [$];
  logic       m_vld [3];
  logic [7:0] m_dat [3];
  logic       m_pe  [3];
  logic       m_fe  [3];
  logic       m_ov  [3];
  int         last_p [3];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         done_r   = 1'b0;

  function automatic int par_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_vld[i] = 1'b0; m_dat[i] = 8'h00; m_pe[i] = 1'b0; m_fe[i] = 1'b0; m_ov[i] = 1'b0;
    end
    evq.delete();
  endtask

  // Compares every receiver against the model each cycle, then advances the
  // model by one cycle using the current data_ready and the expected stops.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) model_clear();
      for (int i = 0; i < 3; i++) begin
        chk("mon_vld", 32'(o_vld[i]), 32'(m_vld[i]));
        chk("mon_ovr", 32'(o_ov[i]), 32'(m_ov[i]));
        if (m_vld[i]) begin
          chk("mon_data", 32'(o_dat[i]), 32'(m_dat[i]));
          chk("mon_perr", 32'(o_pe[i]), 32'(m_pe[i]));
          chk("mon_ferr", 32'(o_fe[i]), 32'(m_fe[i]));
        end
      end
      if (rst_n) begin
        for (int i = 0; i < 3; i++) begin
          bit  hit;
          ev_t e;
          hit = 1'b0;
          e   = '{default: 0};
          for (int k = 0; k < evq.size(); k++) begin
            if (evq[k].idx == i && evq[k].cyc == cyc) begin
              hit = 1'b1;
              e   = evq[k];
            end
          end
          m_ov[i] = 1'b0;
          if (hit) begin
            if (!m_vld[i] || rdy[i]) begin
              m_vld[i] = 1'b1; m_dat[i] = e.d; m_pe[i] = e.pe; m_fe[i] = e.fe;
            end else begin
              m_ov[i] = 1'b1;
            end
          end else if (m_vld[i] && rdy[i]) begin
            m_vld[i] = 1'b0;
          end
        end
        for (int k = evq.size() - 1; k >= 0; k--) begin
          if (evq[k].cyc <= cyc) evq.delete(k);
        end
      end
    end
  endtask

  // Drives one character on receiver i's line. abort_bit >= 0 pulses reset in
  // the middle of that data bit and abandons the frame.
  task automatic send(input int i, input logic [7:0] d, input logic pbit,
                      input logic stopb, input int hold_low, input int abort_bit);
    ev_t e;
    int  ones;
    int  pm;
    pm    = par_of(i);
    ones  = $countones(d) + int'(pbit);
    e.idx = i;
    e.d   = d;
    e.fe  = ~stopb;
    e.pe  = (pm == -1) ? 1'b0 : (pm == 0) ? (ones % 2 == 0) : (ones % 2 == 1);
    last_p[i] = cyc;
    e.cyc = cyc + 2 + HALF + ((pm == -1) ? 9 : 10) * BP;
    rx_l[i] = 1'b0;
    if (abort_bit < 0) evq.push_back(e);
    repeat (BP) tick();
    for (int k = 0; k < 8; k++) begin
      rx_l[i] = d[k];
      if (k == abort_bit) begin
        repeat (BP / 2) tick();
        rst_n   = 1'b0;
        rx_l[i] = 1'b1;
        #1;
        chk("rst_vld",   32'(o_vld[i]), 0);
        chk("rst_data",  32'(o_dat[i]), 0);
        chk("rst_flags", 32'({o_pe[i], o_fe[i], o_ov[i]}), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        return;
      end
      repeat (BP) tick();
    end
    if (pm != -1) begin
      rx_l[i] = pbit;
      repeat (BP) tick();
    end
    rx_l[i] = stopb;
    repeat (BP) tick();
    if (!stopb) begin
      repeat (hold_low) tick();
      rx_l[i] = 1'b1;
      repeat (4) tick();
    end
  endtask

  // Waits for data_valid and pins its cycle (relative to the start edge on
  // the pin) and contents to hand-computed values.
  task automatic expect_byte(input int i, input int off, input logic [7:0] d,
                             input logic pe, input logic fe);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_vld[i] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("vld_seen",  32'(o_vld[i]), 1);
    chk("vld_cycle", cyc - last_p[i], off);
    chk("byte",      32'(o_dat[i]), 32'(d));
    chk("perr",      32'(o_pe[i]), 32'(pe));
    chk("ferr",      32'(o_fe[i]), 32'(fe));
    if (rdy[i]) begin
      @(negedge clk);
      chk("vld_once", 32'(o_vld[i]), 0);
    end
  endtask

  task automatic expect_ov(input int i, input int off);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_ov[i] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("ovr_seen",  32'(o_ov[i]), 1);
    chk("ovr_cycle", cyc - last_p[i], off);
    @(negedge clk);
    chk("ovr_once",  32'(o_ov[i]), 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rx_l[i] = 1'b1;
      rdy[i]  = 1'b1;
      last_p[i] = 0;
    end
    model_clear();
    fork
      monitor();
    join_none

    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("reset_vld",  32'(o_vld[0] | o_vld[1] | o_vld[2]), 0);
    chk("reset_data", 32'(o_dat[0] | o_dat[1] | o_dat[2]), 0);
    chk("reset_ovr",  32'(o_ov[0] | o_ov[1] | o_ov[2]), 0);

    // Odd parity, correct parity bit.
    fork
      send(0, 8'hA5, 1'b1, 1'b1, 0, -1);
      expect_byte(0, 171, 8'hA5, 1'b0, 1'b0);
    join
    // Even parity, same frame: parity error.
    fork
      send(1, 8'hA5, 1'b1, 1'b1, 0, -1);
      expect_byte(1, 171, 8'hA5, 1'b1, 1'b0);
    join
    // No parity bit.
    fork
      send(2, 8'h3C, 1'b0, 1'b1, 0, -1);
      expect_byte(2, 155, 8'h3C, 1'b0, 1'b0);
    join

    // Short glitch is not a start bit.
    rx_l[0] = 1'b0;
    repeat (5) tick();
    rx_l[0] = 1'b1;
    repeat (30) tick();
    fork
      send(0, 8'h55, 1'b1, 1'b1, 0, -1);
      expect_byte(0, 171, 8'h55, 1'b0, 1'b0);
    join

    // Low stop bit followed by a long break.
    fork
      send(0, 8'h66, 1'b1, 1'b0, 100, -1);
      expect_byte(0, 171, 8'h66, 1'b0, 1'b1);
    join
    repeat (10) tick();
    fork
      send(0, 8'h81, 1'b1, 1'b1, 0, -1);
      expect_byte(0, 171, 8'h81, 1'b0, 1'b0);
    join

    // Consumer stalled: second back-to-back byte is dropped.
    rdy[0] = 1'b0;
    send(0, 8'h11, 1'b1, 1'b1, 0, -1);
    fork
      send(0, 8'h22, 1'b1, 1'b1, 0, -1);
      expect_ov(0, 171);
    join
    repeat (5) tick();
    chk("held_byte", 32'(o_dat[0]), 32'h11);
    chk("held_vld",  32'(o_vld[0]), 1);
    rdy[0] = 1'b1;
    repeat (2) tick();
    chk("accepted", 32'(o_vld[0]), 0);

    // Reset in the middle of data bit 4 while a byte is held.
    rdy[0] = 1'b0;
    send(0, 8'h5A, 1'b1, 1'b1, 0, -1);
    send(0, 8'hF0, 1'b0, 1'b1, 0, 4);
    rdy[0] = 1'b1;
    repeat (5) tick();
    fork
      send(0, 8'h0F, 1'b1, 1'b1, 0, -1);
      expect_byte(0, 171, 8'h0F, 1'b0, 1'b0);
    join

    // Randomized characters, parity bits, stop bits, gaps and stalls.
    for (int i = 0; i < 3; i++) begin
      done_r = 1'b0;
      fork
        begin
          for (int f = 0; f < 8; f++) begin
            logic [7:0] d;
            logic       pb;
            logic       sb;
            d  = 8'($urandom);
            pb = 1'($urandom_range(0, 1));
            sb = ($urandom_range(0, 5) != 0);
            send(i, d, pb, sb, 0, -1);
            repeat ($urandom_range(0, 12)) tick();
          end
          repeat (20) tick();
          done_r = 1'b1;
        end
        begin
          while (!done_r) begin
            rdy[i] = ($urandom_range(0, 3) != 0);
            tick();
          end
          rdy[i] = 1'b1;
        end
      join
      repeat (10) tick();
    end

    repeat (20) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
